// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NUM_REQ requesters; optional bursts via DFF_ARB_BURST_EN.
// Latency: req -> gnt 1 cycle, gnt -> q/q_valid 1 cycle; single-write grants leave one idle cycle between grants.
// Backpressure: requesters hold req until served; dropping req while granted abandons the grant with no write.
module dff_bank_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic [$clog2(NUM_REQ)-1:0] q_owner
);

    localparam int IW = $clog2(NUM_REQ);
`ifdef DFF_ARB_BURST_EN
    localparam int BURST_MAX = BURST_LEN;
`else
    localparam int BURST_MAX = 1;
`endif
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       ptr, ptr_nxt;
    logic [IW-1:0]       win, win_nxt;
    logic [IW-1:0]       sel;
    logic                sel_vld;
    logic [IW-1:0]       owner_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [WIDTH-1:0]    q_nxt;
    logic                q_valid_nxt;
    logic [WIDTH-1:0]    win_dat;
    logic [IW-1:0]       win_inc;
    logic                xfer;
    logic                hold;

    // Rotating search starting at the pointer: first pending request wins.
    always_comb begin
        int idx;
        idx     = 0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!sel_vld && req[idx]) begin
                sel_vld = 1'b1;
                sel     = IW'(idx);
            end
        end
    end

    assign win_dat = wdata[int'(win)*WIDTH +: WIDTH];
    assign win_inc = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
    assign xfer    = (state == GRANT) && req[win];
    // With bursts disabled BURST_MAX is 1, so a grant is always released after one write.
    assign hold    = xfer && ((int'(cnt) + 1) < BURST_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            q_owner <= '0;
            ptr     <= '0;
            win     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            q_owner <= owner_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = GRANT;
            GRANT:   if (!hold)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt     = gnt;
        q_nxt       = q;
        q_valid_nxt = 1'b0;
        owner_nxt   = q_owner;
        ptr_nxt     = ptr;
        win_nxt     = win;
        cnt_nxt     = cnt;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                cnt_nxt = '0;
                if (sel_vld) begin
                    gnt_nxt      = '0;
                    gnt_nxt[sel] = 1'b1;
                    win_nxt      = sel;
                end
            end
            GRANT: begin
                if (xfer) begin
                    q_nxt       = win_dat;
                    owner_nxt   = win;
                    q_valid_nxt = 1'b1;
                end
                if (hold) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    gnt_nxt = '0;
                    cnt_nxt = '0;
                    ptr_nxt = win_inc;
                end
            end
            default: begin
                gnt_nxt = '0;
                cnt_nxt = '0;
            end
        endcase
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_gnt_state:  assert property (@(posedge clk) disable iff (reset) (|gnt) |-> (state == GRANT));

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: expected writes are queued when driven and popped on q_valid.
module tb_dff_bank_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req;
    logic [N*W-1:0]     wdata;
    logic [N-1:0]       gnt;
    logic [W-1:0]       q;
    logic               q_valid;
    logic [1:0]         q_owner;

    typedef struct packed {
        logic [1:0]   own;
        logic [W-1:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    dff_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST_LEN(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_owner (q_owner)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (!reset && q_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: q=%h owner=%0d with no write expected", q, q_owner);
            end else begin
                e = exp_q.pop_front();
                if (q !== e.dat || q_owner !== e.own) begin
                    bad++;
                    $display("FAIL write: q=%h owner=%0d, expected q=%h owner=%0d", q, q_owner, e.dat, e.own);
                end
            end
        end
    end

    task automatic set_dat(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    task automatic push(input int own, input logic [W-1:0] v);
        exp_t e;
        e.own = 2'(own);
        e.dat = v;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0 || q !== 8'h00 || q_valid !== 1'b0 || q_owner !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b q=%h q_valid=%b owner=%0d, expected all zero", gnt, q, q_valid, q_owner);
        end
        reset = 1'b0;
        req   = 4'b0001;
        set_dat(0, 8'h77);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL reset_pre_grant: gnt=%b, expected 0001", gnt);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0 || q !== 8'h00 || q_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: gnt=%b q=%h q_valid=%b, expected 0/00/0", gnt, q, q_valid);
        end
        @(negedge clk);
        total++;
        if (q !== 8'h00 || gnt !== 4'b0) begin
            bad++;
            $display("FAIL reset_abort: q=%h gnt=%b, expected q=00 gnt=0000", q, gnt);
        end
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_round_robin;
        logic [N-1:0] eg;
        @(negedge clk);
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_dat(i, 8'(8'h10 + i));
        for (int k = 0; k < 5; k++) push(k % N, 8'(8'h10 + (k % N)));
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % N);
            @(negedge clk);
            total++;
            if (gnt !== eg) begin
                bad++;
                $display("FAIL rr_grant%0d: gnt=%b, expected %b", k, gnt, eg);
            end
            @(negedge clk);
            total++;
            if (gnt !== 4'b0) begin
                bad++;
                $display("FAIL rr_release%0d: gnt=%b, expected 0000", k, gnt);
            end
            if (k == 4) req = '0;
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        req = 4'b0010;
        set_dat(1, 8'hA5);
        push(1, 8'hA5);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010 || q_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_grant: gnt=%b q_valid=%b, expected 0010/0", gnt, q_valid);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        total++;
        if (q_valid !== 1'b0 || q !== 8'hA5 || q_owner !== 2'd1) begin
            bad++;
            $display("FAIL single_hold: q_valid=%b q=%h owner=%0d, expected 0/a5/1", q_valid, q, q_owner);
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        req = 4'b0100;
        set_dat(2, 8'h42);
        push(2, 8'h42);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL wrap_setup: gnt=%b, expected 0100", gnt);
        end
        @(negedge clk);
        req = 4'b1001;
        set_dat(3, 8'h33);
        set_dat(0, 8'h30);
        push(3, 8'h33);
        push(0, 8'h30);
        @(negedge clk);
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_grant3: gnt=%b, expected 1000", gnt);
        end
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_grant0: gnt=%b, expected 0001", gnt);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_abandon;
        @(negedge clk);
        req = 4'b0010;
        set_dat(1, 8'h55);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL abandon_grant: gnt=%b, expected 0010", gnt);
        end
        req = '0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0 || q_valid !== 1'b0 || q !== 8'h30) begin
            bad++;
            $display("FAIL abandon_nowrite: gnt=%b q_valid=%b q=%h, expected 0000/0/30", gnt, q_valid, q);
        end
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_dat(i, 8'(8'h60 + i));
        push(2, 8'h62);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL abandon_next: gnt=%b, expected 0100", gnt);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        total++;
        if (q_valid !== 1'b0) begin
            bad++;
            $display("FAIL abandon_pulse: q_valid=%b, expected 0", q_valid);
        end
    endtask

`ifdef DFF_ARB_BURST_EN
    task automatic test_burst;
        @(negedge clk);
        req = 4'b0001;
        set_dat(0, 8'd1);
        for (int k = 1; k <= 4; k++) push(0, 8'(k));
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL burst_grant: gnt=%b, expected 0001", gnt);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (q_valid !== 1'b1 || gnt !== ((k < 4) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL burst_beat%0d: q_valid=%b gnt=%b", k, q_valid, gnt);
            end
            set_dat(0, 8'(k + 1));
        end
        push(0, 8'd5);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || q_valid !== 1'b0) begin
            bad++;
            $display("FAIL burst_regrant: gnt=%b q_valid=%b, expected 0001/0", gnt, q_valid);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0 || q_valid !== 1'b0) begin
            bad++;
            $display("FAIL burst_end: gnt=%b q_valid=%b, expected 0000/0", gnt, q_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DFF_ARB_BURST_EN
        test_burst();
`else
        test_round_robin();
        test_single();
        test_wrap();
        test_abandon();
`endif
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected writes never seen, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
